// File: rtl/multicycle_cpu_if.sv
// multicycle_cpu_if: instruction-fetch req/ack bus between the core and its instruction memory
interface multicycle_cpu_if #(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16
);
    logic               req;
    logic [DATA_W-1:0]  addr;
    logic               ack;
    logic [INSTR_W-1:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: parametrised multi-cycle core with req/ack fetch and internal register file
module multicycle_cpu #(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    multicycle_cpu_if.master    imem,
    output logic [DATA_W-1:0]   pc,
    output logic [INSTR_W-1:0]  ir,
    output logic [DATA_W-1:0]   alu_out,
    output logic                wb_valid,
    output logic [REG_AW-1:0]   wb_addr,
    output logic                halted
);
    localparam int IMM_W = INSTR_W - 4 - 2 * REG_AW;
    localparam int STEP  = INSTR_W / 8;
    localparam int SH    = $clog2(STEP);
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, WB = 3'd4, HALT = 3'd5;
    logic [2:0]        state;
    logic [DATA_W-1:0] regs [2**REG_AW];
    logic [DATA_W-1:0] a, b, imm, result;
    logic              take;
    logic [3:0]        op;
    logic [REG_AW-1:0] rs, rt, rd, dest;
    logic              writes;
    assign op     = ir[INSTR_W-1 -: 4];
    assign rs     = ir[INSTR_W-5 -: REG_AW];
    assign rt     = ir[INSTR_W-5-REG_AW -: REG_AW];
    assign rd     = ir[INSTR_W-5-2*REG_AW -: REG_AW];
    assign imm    = DATA_W'($signed(ir[IMM_W-1:0]));
    assign writes = !op[3];
    assign dest   = op == 4'd7 ? rt : rd;
    // ALU: ADDI and the branch opcodes fall through to the adder
    always_comb
        result = op == 4'd1 ? a - b :
                 op == 4'd2 ? a & b :
                 op == 4'd3 ? a | b :
                 op == 4'd4 ? ~(a | b) :
                 op == 4'd5 ? ~(a & b) :
                 op == 4'd6 ? DATA_W'($signed(a) < $signed(b)) :
                 a + b;
    assign wb_valid  = state == WB && writes && dest != '0;
    assign wb_addr   = dest;
    assign halted    = state == HALT;
    assign imem.req  = state == FETCH;
    assign imem.addr = pc;
    // FSM and datapath registers; R0 is never written so it always reads zero
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state   <= IDLE;
            pc      <= '0;
            ir      <= '0;
            alu_out <= '0;
            a       <= '0;
            b       <= '0;
            take    <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE:   state <= FETCH;
                FETCH:  if (imem.ack) begin
                            ir    <= imem.rdata;
                            state <= DECODE;
                        end
                DECODE: begin
                            a     <= regs[rs];
                            b     <= op == 4'd7 ? imm : regs[rt];
                            state <= ir == '1 ? HALT : EXEC;
                        end
                EXEC:   begin
                            alu_out <= result;
                            take    <= (op == 4'd8 && a == b) || (op == 4'd9 && a != b);
                            state   <= WB;
                        end
                WB:     begin
                            if (wb_valid) regs[dest] <= alu_out;
                            pc    <= pc + DATA_W'(STEP) + (take ? imm << SH : '0);
                            state <= FETCH;
                        end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: scoreboard bench for multicycle_cpu at 16-bit and 8-bit datapaths
module tb_multicycle_cpu;
    typedef struct { logic [1:0] a; logic [15:0] d; } wb_t;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic rst16_n = 1'b0, rst8_n = 1'b0, hold = 1'b0;
    logic [15:0] mem16 [128];
    logic [15:0] mem8 [128];
    multicycle_cpu_if #(.DATA_W(16), .INSTR_W(16)) bus16 ();
    multicycle_cpu_if #(.DATA_W(8), .INSTR_W(16)) bus8 ();
    assign bus16.ack   = bus16.req && !hold;
    assign bus16.rdata = mem16[bus16.addr[7:1]];
    assign bus8.ack    = bus8.req;
    assign bus8.rdata  = mem8[bus8.addr[7:1]];
    logic [15:0] pc16, ir16, alu16, ir8;
    logic [7:0]  pc8, alu8;
    logic        wbv16, wbv8, halt16, halt8;
    logic [1:0]  wba16, wba8;
    multicycle_cpu dut16 (.clock(clock), .reset_n(rst16_n), .imem(bus16), .pc(pc16), .ir(ir16),
        .alu_out(alu16), .wb_valid(wbv16), .wb_addr(wba16), .halted(halt16));
    multicycle_cpu #(.DATA_W(8), .INSTR_W(16), .REG_AW(2)) dut8 (.clock(clock), .reset_n(rst8_n),
        .imem(bus8), .pc(pc8), .ir(ir8), .alu_out(alu8), .wb_valid(wbv8), .wb_addr(wba8), .halted(halt8));
    int checks = 0, fails = 0;
    wb_t exp16[$], exp8[$];
    logic [15:0] fetch_q[$];
    // scoreboard for the 16-bit core: every write-back pulse must match the next expected write
    always @(negedge clock)
        if (wbv16) begin
            checks++;
            if (exp16.size() == 0) begin
                fails++;
                $display("FAIL wb16 unexpected write r%0d=%h", wba16, alu16);
            end else begin
                wb_t e;
                e = exp16.pop_front();
                if ({wba16, alu16} !== {e.a, e.d}) begin
                    fails++;
                    $display("FAIL wb16 got r%0d=%h expected r%0d=%h", wba16, alu16, e.a, e.d);
                end
            end
        end
    // scoreboard for the 8-bit core
    always @(negedge clock)
        if (wbv8) begin
            checks++;
            if (exp8.size() == 0) begin
                fails++;
                $display("FAIL wb8 unexpected write r%0d=%h", wba8, alu8);
            end else begin
                wb_t e;
                e = exp8.pop_front();
                if ({wba8, 8'h00, alu8} !== {e.a, e.d}) begin
                    fails++;
                    $display("FAIL wb8 got r%0d=%h expected r%0d=%h", wba8, alu8, e.a, e.d);
                end
            end
        end
    // log of accepted fetch addresses of the 16-bit core
    always @(posedge clock)
        if (bus16.req && bus16.ack) fetch_q.push_back(bus16.addr);
    task automatic push16(input logic [1:0] a, input logic [15:0] d);
        wb_t e;
        e.a = a;
        e.d = d;
        exp16.push_back(e);
    endtask
    task automatic reset16(input logic [15:0] p[$]);
        rst16_n = 1'b0;
        hold = 1'b0;
        exp16.delete();
        for (int i = 0; i < 128; i++) mem16[i] = 16'hFFFF;
        foreach (p[i]) mem16[i] = p[i];
        @(negedge clock);
        @(negedge clock);
        fetch_q.delete();
    endtask
    task automatic wait_halt16();
        for (int i = 0; i < 400 && !halt16; i++) @(negedge clock);
        checks++;
        if (!halt16) begin
            fails++;
            $display("FAIL halt16 timeout halted=%b required 1", halt16);
        end
    endtask
    task automatic check_empty16(input string name);
        checks++;
        if (exp16.size() != 0) begin
            fails++;
            $display("FAIL %s pending writes %0d required 0", name, exp16.size());
        end
    endtask
    task automatic check_pc16(input string name, input logic [15:0] want);
        checks++;
        if (pc16 !== want) begin
            fails++;
            $display("FAIL %s pc=%0d required %0d", name, pc16, want);
        end
    endtask
    task automatic test_reset();
        reset16('{16'h710F});
        checks++;
        if ({pc16, ir16, alu16, bus16.req, wbv16, halt16} !== 51'd0) begin
            fails++;
            $display("FAIL reset_outputs pc=%h ir=%h alu=%h req=%b wb=%b halted=%b required all 0",
                pc16, ir16, alu16, bus16.req, wbv16, halt16);
        end
        rst16_n = 1'b1;
        checks++;
        if (bus16.req !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle req=%b required 0", bus16.req);
        end
        @(negedge clock);
        checks++;
        if ({bus16.req, bus16.addr} !== {1'b1, 16'h0}) begin
            fails++;
            $display("FAIL reset_first_fetch req=%b addr=%h required 1/0000", bus16.req, bus16.addr);
        end
        push16(2'd1, 16'd15);
        wait_halt16();
    endtask
    task automatic test_program();
        reset16('{16'h710F, 16'h7207, 16'h26C0, 16'h1780, 16'h3B80, 16'h0BC0, 16'h4B40, 16'h6E40, 16'h6B40});
        push16(2'd1, 16'd15);
        push16(2'd2, 16'd7);
        push16(2'd3, 16'd7);
        push16(2'd2, 16'd8);
        push16(2'd2, 16'd15);
        push16(2'd3, 16'd22);
        push16(2'd1, 16'hFFE0);
        push16(2'd1, 16'd0);
        push16(2'd1, 16'd1);
        rst16_n = 1'b1;
        wait_halt16();
        check_pc16("program_halt_pc", 16'd18);
        repeat (5) @(negedge clock);
        check_pc16("program_pc_frozen", 16'd18);
        checks++;
        if ({halt16, bus16.req} !== 2'b10) begin
            fails++;
            $display("FAIL program_halt_state halted=%b req=%b required 1/0", halt16, bus16.req);
        end
        check_empty16("program_writes");
    endtask
    task automatic test_stall();
        reset16('{16'h710F});
        hold = 1'b1;
        push16(2'd1, 16'd15);
        rst16_n = 1'b1;
        for (int i = 0; i < 10 && !bus16.req; i++) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if ({bus16.req, bus16.addr, wbv16} !== {1'b1, 16'h0, 1'b0}) begin
                fails++;
                $display("FAIL stall_cycle%0d req=%b addr=%h wb=%b required 1/0000/0", i, bus16.req, bus16.addr, wbv16);
            end
        end
        hold = 1'b0;
        @(negedge clock);
        checks++;
        if ({ir16, bus16.req, dut16.state} !== {16'h710F, 1'b0, 3'd2}) begin
            fails++;
            $display("FAIL stall_decode ir=%h req=%b state=%0d required 710f/0/2", ir16, bus16.req, dut16.state);
        end
        wait_halt16();
        check_empty16("stall_writes");
    endtask
    task automatic test_r0();
        reset16('{16'h7005, 16'h0040});
        push16(2'd1, 16'd0);
        rst16_n = 1'b1;
        wait_halt16();
        check_pc16("r0_halt_pc", 16'd4);
        check_empty16("r0_writes");
    endtask
    task automatic test_narrow();
        rst16_n = 1'b0;
        for (int i = 0; i < 128; i++) mem8[i] = 16'hFFFF;
        mem8[0] = 16'h7180;
        mem8[1] = 16'h7201;
        mem8[2] = 16'h66C0;
        exp8.push_back('{2'd1, 16'h0080});
        exp8.push_back('{2'd2, 16'h0001});
        exp8.push_back('{2'd3, 16'h0001});
        @(negedge clock);
        rst8_n = 1'b1;
        for (int i = 0; i < 400 && !halt8; i++) @(negedge clock);
        checks++;
        if ({halt8, pc8} !== {1'b1, 8'd6}) begin
            fails++;
            $display("FAIL narrow_halt halted=%b pc=%0d required 1/6", halt8, pc8);
        end
        checks++;
        if (exp8.size() != 0) begin
            fails++;
            $display("FAIL narrow_writes pending %0d required 0", exp8.size());
        end
        rst8_n = 1'b0;
    endtask
    task automatic test_branch(input logic [15:0] br, input logic [15:0] target);
        reset16('{16'h7105, 16'hA000, br});
        push16(2'd1, 16'd5);
        rst16_n = 1'b1;
        wait_halt16();
        check_pc16("branch_pc", target);
        checks++;
        if (fetch_q.size() != 4 || {fetch_q[0], fetch_q[1], fetch_q[2], fetch_q[3]} !== {16'd0, 16'd2, 16'd4, target}) begin
            fails++;
            $display("FAIL branch_fetches n=%0d last=%0d required 4 fetches ending at %0d",
                fetch_q.size(), fetch_q.size() > 0 ? fetch_q[fetch_q.size()-1] : 16'hx, target);
        end
        check_empty16("branch_writes");
    endtask
    task automatic test_reset_mid();
        reset16('{16'h710F, 16'h05C0});
        push16(2'd1, 16'd15);
        rst16_n = 1'b1;
        for (int i = 0; i < 100 && !(dut16.state == 3'd3 && pc16 == 16'd2); i++) @(negedge clock);
        rst16_n = 1'b0;
        #1;
        checks++;
        if ({pc16, ir16, alu16, bus16.req, wbv16, halt16, dut16.state} !== 54'd0) begin
            fails++;
            $display("FAIL midreset_outputs pc=%h ir=%h alu=%h req=%b wb=%b halted=%b state=%0d required all 0",
                pc16, ir16, alu16, bus16.req, wbv16, halt16, dut16.state);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (dut16.regs[3] !== 16'd0) begin
            fails++;
            $display("FAIL midreset_r3 r3=%h required 0000", dut16.regs[3]);
        end
        check_empty16("midreset_writes");
        push16(2'd1, 16'd15);
        push16(2'd3, 16'd30);
        rst16_n = 1'b1;
        checks++;
        if (bus16.req !== 1'b0) begin
            fails++;
            $display("FAIL midreset_idle req=%b required 0", bus16.req);
        end
        @(negedge clock);
        checks++;
        if ({bus16.req, bus16.addr} !== {1'b1, 16'h0}) begin
            fails++;
            $display("FAIL midreset_refetch req=%b addr=%h required 1/0000", bus16.req, bus16.addr);
        end
        wait_halt16();
        check_empty16("midreset_rerun");
    endtask
    initial begin
        test_reset();
        test_program();
        test_stall();
        test_r0();
        test_narrow();
        test_branch(16'h8503, 16'd12);
        test_branch(16'h9503, 16'd6);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
